// File: rtl/bpred_pkg.sv
// Shared definitions for the branch predictor: counter encodings,
// default table geometry and the sequential-PC increment.
package bpred_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam int          IDX_W_DEF = 4;
  localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/bpred_if.sv
// Fetch-side lookup, EX-side resolution and redirect/statistics signals of the predictor.
interface bpred_if;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  modport master (
    output if_pc, res_valid, res_pc, res_taken, res_target,
           res_pred_taken, res_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, br_cnt, miss_cnt
  );

  modport slave (
    input  if_pc, res_valid, res_pc, res_taken, res_target,
           res_pred_taken, res_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, br_cnt, miss_cnt
  );
endinterface

// File: rtl/bpred_sat_ctr2.sv
// 2-bit saturating counter next-state function (combinational).
module sat_ctr2
  import bpred_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t nxt
);

  always_comb begin
    nxt = ctr;
    case (ctr)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = ctr;
    endcase
  end

endmodule

// File: rtl/bpred.sv
// Direct-mapped dynamic branch predictor: zero-latency lookup at fetch,
// training and registered redirect pulse at branch resolution.
module bpred
  import bpred_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
) (
  input logic   clk,
  input logic   rst_n,
  bpred_if.slave bus
);

  localparam int TAG_W = 30 - IDX_W;
  localparam int DEPTH = 1 << IDX_W;

  logic             tbl_valid  [DEPTH];
  logic [TAG_W-1:0] tbl_tag    [DEPTH];
  logic [31:0]      tbl_target [DEPTH];
  ctr_t             tbl_ctr    [DEPTH];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  ctr_t             lk_ctr;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  ctr_t             up_ctr_nxt;
  logic             miss_det;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.if_pc[1:0], bus.res_pc[1:0]};

  // Lookup reads registered state only; a same-cycle update is not bypassed.
  assign lk_idx = bus.if_pc[IDX_W+1:2];
  assign lk_tag = bus.if_pc[31:IDX_W+2];
  assign lk_ctr = tbl_ctr[lk_idx];
  assign lk_hit = tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);

  assign bus.pred_taken  = lk_hit && lk_ctr[1];
  assign bus.pred_target = bus.pred_taken ? tbl_target[lk_idx] : bus.if_pc + PC_INC;

  assign up_idx = bus.res_pc[IDX_W+1:2];
  assign up_tag = bus.res_pc[31:IDX_W+2];
  assign up_hit = tbl_valid[up_idx] && (tbl_tag[up_idx] == up_tag);

  sat_ctr2 u_sat_ctr2 (
    .ctr   (tbl_ctr[up_idx]),
    .taken (bus.res_taken),
    .nxt   (up_ctr_nxt)
  );

  assign miss_det = bus.res_valid &&
                    ((bus.res_pred_taken != bus.res_taken) ||
                     (bus.res_taken && (bus.res_pred_target != bus.res_target)));

  // Table training: hits train the counter, taken misses allocate (overwriting any alias).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_target[i] <= '0;
        tbl_ctr[i]    <= WNT;
      end
    end else if (bus.res_valid) begin
      if (up_hit) begin
        tbl_ctr[up_idx] <= up_ctr_nxt;
        if (bus.res_taken) tbl_target[up_idx] <= bus.res_target;
      end else if (bus.res_taken) begin
        tbl_valid[up_idx]  <= 1'b1;
        tbl_tag[up_idx]    <= up_tag;
        tbl_target[up_idx] <= bus.res_target;
        tbl_ctr[up_idx]    <= WT;
      end
    end
  end

  // Redirect pulse and performance counters, one cycle after resolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mispredict  <= 1'b0;
      bus.redirect_pc <= '0;
      bus.br_cnt      <= '0;
      bus.miss_cnt    <= '0;
    end else begin
      bus.mispredict <= miss_det;
      if (miss_det) begin
        bus.redirect_pc <= bus.res_taken ? bus.res_target : bus.res_pc + PC_INC;
        bus.miss_cnt    <= bus.miss_cnt + 32'd1;
      end
      if (bus.res_valid) bus.br_cnt <= bus.br_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_bpred.sv
// Directed bench for bpred: lookup, training, aliasing, back-to-back mispredicts, async reset.
module tb_bpred;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bpred_if bus ();

  bpred dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one resolving branch for exactly one cycle; returns at the next negedge.
  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic ptaken, input logic [31:0] ptgt);
    bus.res_valid       = 1'b1;
    bus.res_pc          = pc;
    bus.res_taken       = taken;
    bus.res_target      = tgt;
    bus.res_pred_taken  = ptaken;
    bus.res_pred_target = ptgt;
    @(negedge clk);
    bus.res_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic taken,
                        input logic [31:0] tgt);
    bus.if_pc = pc;
    #1;
    check({tag, "_taken"}, {31'd0, bus.pred_taken}, {31'd0, taken});
    check({tag, "_target"}, bus.pred_target, tgt);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.if_pc = '0;
    bus.res_valid = 1'b0;
    bus.res_pc = '0;
    bus.res_taken = 1'b0;
    bus.res_target = '0;
    bus.res_pred_taken = 1'b0;
    bus.res_pred_target = '0;
    repeat (3) @(negedge clk);
    check("rst_mispredict", {31'd0, bus.mispredict}, 32'd0);
    check("rst_redirect", bus.redirect_pc, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_br_cnt", bus.br_cnt, 32'd0);
    check("rst_miss_cnt", bus.miss_cnt, 32'd0);
    lookup("cold", 32'h0040_0010, 1'b0, 32'h0040_0014);

    // First taken resolution allocates and mispredicts.
    @(negedge clk);
    resolve(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
    check("alloc_mispredict", {31'd0, bus.mispredict}, 32'd1);
    check("alloc_redirect", bus.redirect_pc, 32'h0040_0100);
    check("alloc_br_cnt", bus.br_cnt, 32'd1);
    check("alloc_miss_cnt", bus.miss_cnt, 32'd1);
    lookup("alloc_lk", 32'h0040_0010, 1'b1, 32'h0040_0100);
    @(negedge clk);
    check("pulse_one_cycle", {31'd0, bus.mispredict}, 32'd0);

    // Three correct taken predictions back to back: ctr 10 -> 11 -> 11 -> 11.
    for (int i = 0; i < 3; i++) begin
      resolve(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100);
      check("correct_no_pulse", {31'd0, bus.mispredict}, 32'd0);
    end
    check("redirect_hold", bus.redirect_pc, 32'h0040_0100);
    // Not taken once: ctr 11 -> 10, still predicts taken.
    resolve(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
    check("nt_mispredict", {31'd0, bus.mispredict}, 32'd1);
    check("nt_redirect", bus.redirect_pc, 32'h0040_0014);
    lookup("ctr10", 32'h0040_0010, 1'b1, 32'h0040_0100);
    // Not taken again: ctr 10 -> 01, now predicts not taken.
    resolve(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
    check("nt2_mispredict", {31'd0, bus.mispredict}, 32'd1);
    lookup("ctr01", 32'h0040_0010, 1'b0, 32'h0040_0014);
    check("cnt6_br", bus.br_cnt, 32'd6);
    check("cnt6_miss", bus.miss_cnt, 32'd3);

    // Alias at the same index with a new tag replaces the entry.
    resolve(32'h0040_0050, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0054);
    check("alias_redirect", bus.redirect_pc, 32'h0040_0200);
    lookup("alias_old", 32'h0040_0010, 1'b0, 32'h0040_0014);
    lookup("alias_new", 32'h0040_0050, 1'b1, 32'h0040_0200);

    // Not-taken miss leaves the table alone.
    resolve(32'h0040_0090, 1'b0, 32'h0040_0900, 1'b0, 32'h0040_0094);
    check("ntmiss_no_pulse", {31'd0, bus.mispredict}, 32'd0);
    lookup("ntmiss_keep", 32'h0040_0050, 1'b1, 32'h0040_0200);
    lookup("ntmiss_noalloc", 32'h0040_0090, 1'b0, 32'h0040_0094);

    // Right direction, wrong target: mispredict and target retrained.
    resolve(32'h0040_0050, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0200);
    check("tgt_mispredict", {31'd0, bus.mispredict}, 32'd1);
    check("tgt_redirect", bus.redirect_pc, 32'h0040_0300);
    lookup("tgt_lk", 32'h0040_0050, 1'b1, 32'h0040_0300);
    check("cnt9_br", bus.br_cnt, 32'd9);
    check("cnt9_miss", bus.miss_cnt, 32'd5);

    // Two consecutive mispredicts give two consecutive pulses.
    resolve(32'h0040_0020, 1'b1, 32'h0040_0400, 1'b0, 32'h0040_0024);
    check("b2b1_mispredict", {31'd0, bus.mispredict}, 32'd1);
    check("b2b1_redirect", bus.redirect_pc, 32'h0040_0400);
    resolve(32'h0040_0030, 1'b0, 32'h0040_0500, 1'b1, 32'h0040_0500);
    check("b2b2_mispredict", {31'd0, bus.mispredict}, 32'd1);
    check("b2b2_redirect", bus.redirect_pc, 32'h0040_0034);
    check("b2b_br", bus.br_cnt, 32'd11);
    check("b2b_miss", bus.miss_cnt, 32'd7);
    @(negedge clk);
    check("b2b_end", {31'd0, bus.mispredict}, 32'd0);

    // Same-cycle lookup of an index being updated sees old contents.
    bus.if_pc = 32'h0040_0020;
    bus.res_valid = 1'b1;
    bus.res_pc = 32'h0040_0020;
    bus.res_taken = 1'b0;
    bus.res_target = 32'h0040_0400;
    bus.res_pred_taken = 1'b1;
    bus.res_pred_target = 32'h0040_0400;
    #1;
    check("nobypass_taken", {31'd0, bus.pred_taken}, 32'd1);
    check("nobypass_target", bus.pred_target, 32'h0040_0400);
    @(negedge clk);
    bus.res_valid = 1'b0;
    check("nobypass_redirect", bus.redirect_pc, 32'h0040_0024);
    lookup("nobypass_after", 32'h0040_0020, 1'b0, 32'h0040_0024);

    // Asynchronous reset while a mispredicting branch resolves.
    @(negedge clk);
    resolve(32'h0040_0060, 1'b1, 32'h0040_0600, 1'b0, 32'h0040_0064);
    check("prerst_mispredict", {31'd0, bus.mispredict}, 32'd1);
    bus.res_valid = 1'b1;
    bus.res_pc = 32'h0040_0070;
    bus.res_taken = 1'b1;
    bus.res_target = 32'h0040_0700;
    bus.res_pred_taken = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mispredict", {31'd0, bus.mispredict}, 32'd0);
    check("arst_redirect", bus.redirect_pc, 32'd0);
    check("arst_br_cnt", bus.br_cnt, 32'd0);
    check("arst_miss_cnt", bus.miss_cnt, 32'd0);
    lookup("arst_lk", 32'h0040_0050, 1'b0, 32'h0040_0054);
    @(negedge clk);
    check("arst_hold", {31'd0, bus.mispredict}, 32'd0);
    bus.res_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_no_pulse", {31'd0, bus.mispredict}, 32'd0);
    check("arst_br_after", bus.br_cnt, 32'd0);
    lookup("arst_lk2", 32'h0040_0060, 1'b0, 32'h0040_0064);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bpred.md
# bpred

Dynamic branch predictor paired with the EX-stage branch comparator. At fetch it predicts direction and target for `if_pc` from a direct-mapped table of 2-bit saturating counters and branch targets. When the comparator's resolved `branch` outcome reaches it, it trains the table and raises a registered one-cycle redirect on misprediction. It sits between the IF-stage PC mux and the EX-stage branch resolution.

## Interface
- `IDX_W`, default 4: table index width; there are 2^IDX_W entries, indexed by PC[IDX_W+1:2].
- `TAG_W`, derived as 30-IDX_W: tag width, taken from PC[31:IDX_W+2].
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `if_pc` input, 32 bits: fetch PC to predict.
- `pred_taken` output, 1 bit: predicted taken for `if_pc`.
- `pred_target` output, 32 bits: predicted next PC for `if_pc`.
- `res_valid` input, 1 bit: a branch is resolving this cycle (comparator `compare` qualified by a valid EX instruction).
- `res_pc` input, 32 bits: PC of the resolving branch.
- `res_taken` input, 1 bit: resolved direction (comparator `branch`).
- `res_target` input, 32 bits: resolved taken target.
- `res_pred_taken` input, 1 bit: prediction made at fetch, carried down the pipeline.
- `res_pred_target` input, 32 bits: predicted target carried down the pipeline.
- `mispredict` output, 1 bit: registered one-cycle flush/redirect pulse.
- `redirect_pc` output, 32 bits: correct next PC; valid while `mispredict`=1.
- `br_cnt` output, 32 bits: count of resolved branches.
- `miss_cnt` output, 32 bits: count of mispredictions.

## Operation
- Each entry holds `valid`, `tag[TAG_W]`, `target[32]`, and `ctr[2]`.
- Lookup is combinational from registered state:
  - hit = valid[idx] && tag[idx]==if_pc tag.
  - pred_taken = hit && ctr[idx][1].
  - pred_target = pred_taken ? target[idx] : if_pc+4, with 32-bit wrap.
- Update on `res_valid`, at the index and tag of `res_pc`:
  - On hit: ctr saturates up (max 2'b11) if `res_taken`, down (min 2'b00) otherwise. If `res_taken`, target <= res_target.
  - On miss with `res_taken`=1: allocate. Set valid=1, write the tag, target=res_target, ctr=2'b10; any existing entry is overwritten.
  - On miss with `res_taken`=0: the table is unchanged.
- Misprediction is detected on `res_valid` when either condition holds:
  - res_pred_taken != res_taken, or
  - res_taken && res_pred_target != res_target.
- On detection, the next edge sets mispredict=1 and redirect_pc = res_taken ? res_target : res_pc+4. Otherwise mispredict=0 and redirect_pc holds its value.
- `br_cnt` increments on every `res_valid`. `miss_cnt` increments on every detected mispredict. Both wrap at 2^32.

## Timing
- Reset values:
  - all valid=0, all ctr=2'b01, tags and targets 0;
  - mispredict=0, redirect_pc=0, br_cnt=0, miss_cnt=0.
- Prediction has zero latency: outputs follow `if_pc` within the same cycle.
- Table updates land on the edge ending the `res_valid` cycle. A same-cycle lookup of the same index sees the old contents, with no bypass.
- `mispredict` asserts exactly one cycle after the resolving cycle and lasts one cycle per mispredicted branch.
- Back-to-back `res_valid` cycles are all processed. Consecutive mispredicts give consecutive pulses, each with its own redirect_pc.
- Asserting `rst_n` mid-operation clears all state immediately. No pulse is emitted for a branch resolving in that cycle.

## Structure
- Shared datapath package holds:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - default IDX_W;
  - the PC+4 increment constant.
- One sub-module, `sat_ctr2`: the 2-bit saturating next-state function, combinational, instantiated once on the update path.
- Table arrays and the redirect/performance-counter registers live in `bpred`.

## Test plan
- Reset, then if_pc=0x0040_0010 -> pred_taken=0, pred_target=0x0040_0014; br_cnt=0, miss_cnt=0.
- Resolve res_pc=0x0040_0010, taken, res_target=0x0040_0100, res_pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x0040_0100. The following lookup of 0x0040_0010 gives pred_taken=1, pred_target=0x0040_0100.
- Same branch resolved taken 3 more times, then not-taken once -> ctr goes 10→11→11→11→10 and still predicts taken. Not-taken with res_pred_taken=1 -> mispredict=1, redirect_pc=0x0040_0014.
- Alias: res_pc=0x0040_0050 (same index, new tag), taken, target 0x0040_0200 -> entry replaced, ctr=10. Lookup of 0x0040_0010 now misses and predicts 0x0040_0014.
- Two consecutive mispredicting resolutions -> two consecutive single-cycle pulses with the correct redirect_pc each. br_cnt and miss_cnt each increase by 2.
- Drive rst_n low asynchronously while res_valid=1 -> mispredict=0 immediately and the table is invalidated. The next lookup predicts not-taken.
